// File: rtl/cgra_x_heep_top_pkg.sv
// rtl/cgra_x_heep_top_pkg.sv - shared constants and types for the CGRA column arbiter
// Contents:
//   EXT_XBAR_NMASTER          number of CGRA column masters on the external crossbar
//   CGRA_START_ADDRESS        first address of the legal CGRA access window (inclusive)
//   CGRA_END_ADDRESS          end of the legal CGRA access window (exclusive)
//   cgra_arb_id_t             response-routing FIFO entry: column index (+ err flag when
//                             CGRA_ARB_ADDR_CHECK_EN is defined)
//   cgra_addr_in_window()     window membership helper
package cgra_x_heep_top_pkg;

  localparam int unsigned EXT_XBAR_NMASTER = 4;

  localparam logic [31:0] CGRA_START_ADDRESS = 32'h0000_0040;
  localparam logic [31:0] CGRA_END_ADDRESS   = 32'h0001_0000;

  // Wide enough for any realistic column count; the arbiter truncates to its own width.
  localparam int unsigned CGRA_ARB_IDX_W = 8;

  typedef struct packed {
`ifdef CGRA_ARB_ADDR_CHECK_EN
    logic                      err;
`endif
    logic [CGRA_ARB_IDX_W-1:0] idx;
  } cgra_arb_id_t;

  function automatic logic cgra_addr_in_window(input logic [31:0] addr);
    return (addr >= CGRA_START_ADDRESS) && (addr < CGRA_END_ADDRESS);
  endfunction

endpackage

// File: rtl/cgra_arb_id_fifo.sv
// rtl/cgra_arb_id_fifo.sv - in-order ID FIFO that routes crossbar responses back to columns
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset (empties the FIFO)
//   push_i, push_data_i     enqueue one entry (ignored while full)
//   pop_i                   dequeue the head entry (ignored while empty)
//   full_o, empty_o         occupancy flags
//   head_o                  oldest entry
module cgra_arb_id_fifo
  import cgra_x_heep_top_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  cgra_arb_id_t push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output cgra_arb_id_t head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cgra_arb_id_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cgra_column_arbiter.sv
// rtl/cgra_column_arbiter.sv - round-robin arbiter merging CGRA column OBI masters onto one crossbar port
// Optional feature: define CGRA_ARB_ADDR_CHECK_EN to answer out-of-window requests locally with an error.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   col_req_i/we_i/addr_i/be_i/wdata_i   per-column OBI request
//   col_gnt_o                            per-column grant (combinational from slv_gnt_i)
//   col_rvalid_o/err_o/rdata_o           per-column response
//   slv_req_o/we_o/addr_o/be_o/wdata_o   merged request toward the crossbar
//   slv_gnt_i, slv_rvalid_i, slv_rdata_i crossbar grant and response
module cgra_column_arbiter
  import cgra_x_heep_top_pkg::*;
#(
  parameter int unsigned NMASTER         = EXT_XBAR_NMASTER,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NMASTER-1:0]        col_req_i,
  input  logic [NMASTER-1:0]        col_we_i,
  input  logic [NMASTER-1:0][31:0]  col_addr_i,
  input  logic [NMASTER-1:0][3:0]   col_be_i,
  input  logic [NMASTER-1:0][31:0]  col_wdata_i,
  output logic [NMASTER-1:0]        col_gnt_o,
  output logic [NMASTER-1:0]        col_rvalid_o,
  output logic [NMASTER-1:0]        col_err_o,
  output logic [NMASTER-1:0][31:0]  col_rdata_o,
  output logic                      slv_req_o,
  output logic                      slv_we_o,
  output logic [31:0]               slv_addr_o,
  output logic [3:0]                slv_be_o,
  output logic [31:0]               slv_wdata_o,
  input  logic                      slv_gnt_i,
  input  logic                      slv_rvalid_i,
  input  logic [31:0]               slv_rdata_i
);

  localparam int unsigned IW = (NMASTER > 1) ? $clog2(NMASTER) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic          rst_q;
  logic [IW-1:0] win, cand, head_idx;
  logic          found, active, sel_err, issue_ok, accept, fifo_pop;
  logic          fifo_full, fifo_empty;
  cgra_arb_id_t  push_data, head;

  // Outputs stay quiet during reset and the cycle after it.
  assign active = ~(rst_i | rst_q);

  // Round-robin search from ptr; a stalled request keeps its column until granted.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < int'(NMASTER); k++) begin
      cand = IW'((int'(ptr_q) + k) % int'(NMASTER));
      if (!found && col_req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    if (lock_q) begin
      found = 1'b1;
      win   = lock_idx_q;
    end
  end

`ifdef CGRA_ARB_ADDR_CHECK_EN
  assign sel_err = ~cgra_addr_in_window(col_addr_i[win]);
`else
  assign sel_err = 1'b0;
`endif

  assign issue_ok  = active & found & ~fifo_full;
  assign slv_req_o = issue_ok & ~sel_err;
  // Error requests are accepted locally without waiting for the crossbar.
  assign accept    = (slv_req_o & slv_gnt_i) | (issue_ok & sel_err);

  assign slv_we_o    = active & col_we_i[win];
  assign slv_addr_o  = active ? col_addr_i[win]  : '0;
  assign slv_be_o    = active ? col_be_i[win]    : '0;
  assign slv_wdata_o = active ? col_wdata_i[win] : '0;

  always_comb begin
    col_gnt_o = '0;
    if (accept) col_gnt_o[win] = 1'b1;
  end

  always_comb begin
    push_data     = '0;
    push_data.idx = CGRA_ARB_IDX_W'(win);
`ifdef CGRA_ARB_ADDR_CHECK_EN
    push_data.err = sel_err;
`endif
  end

  assign ptr_d      = accept ? ((win == IW'(NMASTER - 1)) ? '0 : win + 1'b1) : ptr_q;
  assign lock_d     = slv_req_o & ~slv_gnt_i;
  assign lock_idx_d = win;

  assign head_idx = IW'(head.idx);

  // Response routing: the FIFO head names the column owed the next response.
  always_comb begin
    fifo_pop     = 1'b0;
    col_rvalid_o = '0;
    col_err_o    = '0;
    col_rdata_o  = '0;
    if (active && !fifo_empty) begin
`ifdef CGRA_ARB_ADDR_CHECK_EN
      if (head.err) begin
        fifo_pop               = 1'b1;
        col_rvalid_o[head_idx] = 1'b1;
        col_err_o[head_idx]    = 1'b1;
      end else
`endif
      if (slv_rvalid_i) begin
        fifo_pop               = 1'b1;
        col_rvalid_o[head_idx] = 1'b1;
        col_rdata_o[head_idx]  = slv_rdata_i;
      end
    end
  end

  cgra_arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (accept),
    .push_data_i(push_data),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rst_q      <= 1'b1;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rst_q      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cgra_column_arbiter.sv
// tb/tb_cgra_column_arbiter.sv - scoreboard bench for cgra_column_arbiter
module tb_cgra_column_arbiter;
  import cgra_x_heep_top_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       col_req, col_we;
  logic [3:0][31:0] col_addr, col_wdata;
  logic [3:0][3:0]  col_be;
  logic [3:0]       col_gnt, col_rvalid, col_err;
  logic [3:0][31:0] col_rdata;
  logic             slv_req, slv_we, slv_gnt, slv_rvalid;
  logic [31:0]      slv_addr, slv_wdata, slv_rdata;
  logic [3:0]       slv_be;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          col;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int   gnt_q[$];
  rsp_t rsp_q[$];

  always #5 clk = ~clk;

  cgra_column_arbiter #(.NMASTER(4), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .col_req_i(col_req), .col_we_i(col_we), .col_addr_i(col_addr),
    .col_be_i(col_be), .col_wdata_i(col_wdata),
    .col_gnt_o(col_gnt), .col_rvalid_o(col_rvalid), .col_err_o(col_err),
    .col_rdata_o(col_rdata),
    .slv_req_o(slv_req), .slv_we_o(slv_we), .slv_addr_o(slv_addr),
    .slv_be_o(slv_be), .slv_wdata_o(slv_wdata),
    .slv_gnt_i(slv_gnt), .slv_rvalid_i(slv_rvalid), .slv_rdata_i(slv_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every grant and response the DUT presents must match the next scoreboard entry.
  int          m_col;
  rsp_t        m_rsp;
  logic [127:0] m_rd;
  always @(negedge clk) begin
    if (col_gnt != 4'b0) begin
      if (gnt_q.size() == 0) chk("unexpected_gnt", 128'(col_gnt), 128'h0);
      else begin
        m_col = gnt_q.pop_front();
        chk("gnt_col", 128'(col_gnt), 128'(4'b1 << m_col));
      end
    end
    if (col_rvalid != 4'b0) begin
      if (rsp_q.size() == 0) chk("unexpected_rvalid", 128'(col_rvalid), 128'h0);
      else begin
        m_rsp = rsp_q.pop_front();
        m_rd  = 128'(m_rsp.data) << (32 * m_rsp.col);
        chk("rsp_rvalid", 128'(col_rvalid), 128'(4'b1 << m_rsp.col));
        chk("rsp_rdata", col_rdata, m_rd);
        chk("rsp_err", 128'(col_err), m_rsp.err ? 128'(4'b1 << m_rsp.col) : 128'h0);
      end
    end else if (col_err != 4'b0 || col_rdata != '0) begin
      chk("idle_rsp_lanes", {col_err, col_rdata}, 128'h0);
    end
  end

  task automatic drive(input logic r, input logic [3:0] req, input logic g,
                       input logic rv, input logic [31:0] rd);
    rst = r; col_req = req; slv_gnt = g; slv_rvalid = rv; slv_rdata = rd;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_slv"}, {slv_req, slv_we, slv_addr, slv_be, slv_wdata}, 128'h0);
    chk({name, "_col"}, {col_gnt, col_rvalid, col_err}, 128'h0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      col_addr[i]  = 32'h0000_0100 + 32'(16 * i);
      col_wdata[i] = 32'hD000_0000 + 32'(i);
      col_be[i]    = 4'hF ^ 4'(i);
    end
    col_we = 4'b0101;
    drive(1, 4'hF, 1, 1, 32'h1111_1111);
    nxt;

    // Reset cycle and the cycle after it: everything quiet despite active inputs.
    @(negedge clk); chk_quiet("reset");
    nxt;
    drive(0, 4'hF, 1, 1, 32'h2222_2222);
    @(negedge clk); chk_quiet("post_reset");
    nxt;

    // All columns request, immediate responses: grants 0,1,2,3,0.
    for (int k = 0; k < 6; k++) begin
      drive(0, (k < 5) ? 4'hF : 4'h0, 1, k > 0, 32'hA000_0000 + 32'(k) - 32'd1);
      if (k < 5) begin
        gnt_q.push_back(k % 4);
        rsp_q.push_back('{k % 4, 32'hA000_0000 + 32'(k), 1'b0});
      end
      @(negedge clk);
      if (k < 5) begin
        chk("rr_addr", 128'(slv_addr), 128'(col_addr[k % 4]));
        chk("rr_wdata", 128'(slv_wdata), 128'(col_wdata[k % 4]));
        chk("rr_we_be", 128'({slv_we, slv_be}), 128'({col_we[k % 4], col_be[k % 4]}));
      end
      nxt;
    end
    // Occupancy stayed at one: a further rvalid must be ignored.
    drive(0, 4'h0, 0, 1, 32'hDEAD_0001);
    @(negedge clk); nxt;

    // Column 2 stalls 3 cycles; column 1 joins mid-stall but the selection stays locked.
    col_addr[2] = 32'h0000_0040;
    for (int s = 0; s < 4; s++) begin
      drive(0, (s == 1 || s == 2) ? 4'b0110 : 4'b0100, s == 3, 0, 32'h0);
      if (s == 3) begin
        gnt_q.push_back(2);
        rsp_q.push_back('{2, 32'hB000_0002, 1'b0});
      end
      @(negedge clk);
      chk("stall_req", 128'(slv_req), 128'h1);
      chk("stall_addr", 128'(slv_addr), 128'h40);
      nxt;
    end
    // ptr must now be 3: columns 0 and 3 both request, 3 wins.
    drive(0, 4'b1001, 1, 1, 32'hB000_0002);
    gnt_q.push_back(3); rsp_q.push_back('{3, 32'hB000_0003, 1'b0});
    @(negedge clk); nxt;
    drive(0, 4'b0001, 1, 1, 32'hB000_0003);
    gnt_q.push_back(0); rsp_q.push_back('{0, 32'hB000_0000, 1'b0});
    @(negedge clk); nxt;
    drive(0, 4'b0000, 0, 1, 32'hB000_0000);
    @(negedge clk); nxt;

    // FIFO full gating: two grants, then issue held off until one response returns.
    drive(0, 4'b0111, 1, 0, 32'h0);
    gnt_q.push_back(1); rsp_q.push_back('{1, 32'hE000_0001, 1'b0});
    @(negedge clk); nxt;
    drive(0, 4'b0101, 1, 0, 32'h0);
    gnt_q.push_back(2); rsp_q.push_back('{2, 32'hE000_0002, 1'b0});
    @(negedge clk); nxt;
    drive(0, 4'b0001, 1, 0, 32'h0);
    @(negedge clk); chk("full_gate", 128'(slv_req), 128'h0); nxt;
    drive(0, 4'b0001, 1, 1, 32'hE000_0001);
    @(negedge clk); chk("full_gate_pop_cycle", 128'(slv_req), 128'h0); nxt;
    drive(0, 4'b0001, 1, 1, 32'hE000_0002);
    gnt_q.push_back(0); rsp_q.push_back('{0, 32'hE000_0000, 1'b0});
    @(negedge clk); chk("reopen", 128'(slv_req), 128'h1); nxt;
    drive(0, 4'b0000, 0, 1, 32'hE000_0000);
    @(negedge clk); nxt;
    drive(0, 4'b0000, 0, 1, 32'hDEAD_0002);
    @(negedge clk); chk("empty_ignore", 128'(col_rvalid), 128'h0); nxt;

    // Reset with two IDs in flight: later rvalids go nowhere and ptr restarts at 0.
    drive(0, 4'b0110, 1, 0, 32'h0);
    gnt_q.push_back(1);
    @(negedge clk); nxt;
    drive(0, 4'b0100, 1, 0, 32'h0);
    gnt_q.push_back(2);
    @(negedge clk); nxt;
    drive(1, 4'hF, 1, 1, 32'hDEAD_0003);
    @(negedge clk); chk_quiet("mid_reset"); nxt;
    drive(0, 4'hF, 1, 1, 32'hDEAD_0004);
    @(negedge clk); chk_quiet("mid_post_reset"); nxt;
    drive(0, 4'b0000, 0, 1, 32'hDEAD_0005);
    @(negedge clk); chk("flushed_ids", 128'(col_rvalid), 128'h0); nxt;
    drive(0, 4'b1001, 1, 0, 32'h0);
    gnt_q.push_back(0); rsp_q.push_back('{0, 32'hF000_0000, 1'b0});
    @(negedge clk); chk("ptr_after_reset", 128'(slv_addr), 128'(col_addr[0])); nxt;
    drive(0, 4'b0000, 0, 1, 32'hF000_0000);
    @(negedge clk); nxt;

`ifdef CGRA_ARB_ADDR_CHECK_EN
    // Column 1 at CGRA_END_ADDRESS: answered locally with an error after column 0 drains.
    drive(0, 4'b0001, 1, 0, 32'h0);
    gnt_q.push_back(0); rsp_q.push_back('{0, 32'hC000_0000, 1'b0});
    @(negedge clk); nxt;
    col_addr[1] = CGRA_END_ADDRESS;
    drive(0, 4'b0010, 1, 0, 32'h0);
    gnt_q.push_back(1); rsp_q.push_back('{1, 32'h0, 1'b1});
    @(negedge clk); chk("err_not_fwd", 128'(slv_req), 128'h0); nxt;
    drive(0, 4'b0000, 0, 1, 32'hC000_0000);
    @(negedge clk); nxt;
    drive(0, 4'b0000, 0, 0, 32'h0);
    @(negedge clk); nxt;
`endif

    drive(0, 4'b0000, 0, 0, 32'h0);
    @(negedge clk); nxt;
    @(negedge clk);
    chk("gnt_q_drained", 128'(gnt_q.size()), 128'h0);
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cgra_column_arbiter.md
CGRA_COLUMN_ARBITER -- requirements
Module: cgra_column_arbiter

Interface
REQ-001 SHALL have parameter NMASTER, default 4: number of CGRA column OBI masters.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2: depth of the response-routing ID FIFO.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have ports col_req_i, col_we_i and col_gnt_o: NMASTER bits each, in/in/out; per-column request, write enable and grant.
REQ-006 SHALL have ports col_addr_i and col_wdata_i, input, NMASTER x 32: per-column address and write data.
REQ-007 SHALL have port col_be_i, input, NMASTER x 4: per-column byte enables.
REQ-008 SHALL have ports col_rvalid_o and col_err_o, output, NMASTER: per-column response valid and error flag.
REQ-009 SHALL have port col_rdata_o, output, NMASTER x 32: per-column read data.
REQ-010 SHALL have ports slv_req_o, slv_we_o, slv_addr_o (32), slv_be_o (4) and slv_wdata_o (32), all outputs: the single request toward the external crossbar.
REQ-011 SHALL have ports slv_gnt_i, slv_rvalid_i and slv_rdata_i (32), all inputs: the crossbar's grant and response.

Function
REQ-012 SHALL arbitrate round-robin: the winner is the first requesting column at or after ptr, searching upward modulo NMASTER.
REQ-013 SHALL set ptr to (winner+1) mod NMASTER on each accepted handshake (slv_req_o & slv_gnt_i), and hold ptr otherwise.
REQ-014 SHALL lock the selection while slv_req_o=1 and slv_gnt_i=0, keeping slv_addr/we/be/wdata stable until grant.
REQ-015 SHALL drive col_gnt_o[winner]=slv_gnt_i in the handshake cycle (combinational, zero-cycle), with all other col_gnt_o bits 0.
REQ-016 SHALL gate slv_req_o to 0 while the ID FIFO holds MAX_OUTSTANDING entries.
REQ-017 SHALL push the winner index into the ID FIFO on each handshake and pop the FIFO on each slv_rvalid_i.
REQ-018 SHALL, on slv_rvalid_i, drive col_rvalid_o[head]=1 and col_rdata_o[head]=slv_rdata_i in the same cycle, with col_err_o[head]=0.
REQ-019 SHALL allow push and pop in the same cycle when not full, leaving the occupancy unchanged.
REQ-020 SHALL wrap the FIFO read and write pointers modulo MAX_OUTSTANDING.
REQ-021 SHALL ignore slv_rvalid_i when the FIFO is empty (no pop, no col_rvalid_o).
REQ-022 SHALL drive unselected col_rdata_o lanes to 0.
REQ-023 SHALL return responses strictly in issue order.

Reset
REQ-024 SHALL, while rst_i=1, clear ptr to 0, empty the FIFO and drop the lock.
REQ-025 SHALL force every output to 0 in the cycle rst_i=1 and the cycle after it.
REQ-026 SHALL discard in-flight IDs on reset mid-operation; later slv_rvalid_i is then ignored per REQ-021.

Configuration
REQ-027 SHALL, with CGRA_ARB_ADDR_CHECK_EN defined, treat a winner whose address lies outside [CGRA_START_ADDRESS, CGRA_END_ADDRESS) as an error request.
REQ-028 SHALL handle an error request as follows: not forwarded (slv_req_o=0 for it), col_gnt_o=1 locally that cycle, ID pushed with err flag set, ptr advanced.
REQ-029 SHALL, when the FIFO head carries the err flag, pop it without slv_rvalid_i and drive col_rvalid_o=1, col_err_o=1 and col_rdata_o=0 for that column.
REQ-030 SHALL, with CGRA_ARB_ADDR_CHECK_EN not defined, forward all requests, never assert col_err_o, and omit the err flag from FIFO entries.

Structure
REQ-031 SHALL take the NMASTER default from EXT_XBAR_NMASTER and the window constants CGRA_START_ADDRESS/CGRA_END_ADDRESS from the shared package cgra_x_heep_top_pkg.
REQ-032 SHALL define the FIFO entry typedef cgra_arb_id_t (column index plus err flag) in that package.
REQ-033 SHALL implement the FIFO as sub-module cgra_arb_id_fifo (push, pop, full, empty, head).

Verification
REQ-034 SHALL cover: all 4 columns request continuously with slv_gnt_i=1 and immediate rvalid -> grants in order 0,1,2,3,0; each rdata returned to its issuing column.
REQ-035 SHALL cover: column 2 requests addr 0x0000_0040 (in window) with slv_gnt_i low for 3 cycles -> slv_addr_o stable at 0x0000_0040 for 4 cycles; col_gnt_o[2] only in the 4th cycle; ptr=3 afterwards.
REQ-036 SHALL cover: MAX_OUTSTANDING=2 with 2 grants and no rvalid -> slv_req_o=0 with a third request pending; one slv_rvalid_i reopens issue next cycle.
REQ-037 SHALL cover: handshake and slv_rvalid_i in the same cycle with 1 entry outstanding -> occupancy stays 1; response routed to the older column.
REQ-038 SHALL cover: CGRA_ARB_ADDR_CHECK_EN defined, column 1 addr = CGRA_END_ADDRESS -> slv_req_o=0, col_gnt_o[1]=1, then col_rvalid_o[1]=1, col_err_o[1]=1, col_rdata_o[1]=0 after prior responses drain.
REQ-039 SHALL cover: rst_i asserted with 2 entries outstanding, then slv_rvalid_i pulsed -> no col_rvalid_o; ptr=0.
